// File: rtl/seq_div_16.sv
// 16-bit restoring divider, one quotient bit per cycle, signed or unsigned.
// Divide-by-zero and signed 0x8000/-1 finish early, one cycle after start.
module seq_div_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        isSigned,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        divByZero,
    output logic        ovfl
);

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           last;
    logic           early_dbz;
    logic           early_ov;
    logic           neg_q;
    logic           neg_r;
    logic [W-1:0]   dvd_raw;
    logic [W-1:0]   dvs_mag;
    logic [W-1:0]   q_sh;
    logic [W-1:0]   r_acc;

    // Operand decode at acceptance
    logic           accept_c;
    logic           dvd_neg_c;
    logic           dvs_neg_c;
    logic [W-1:0]   dvd_mag_c;
    logic [W-1:0]   dvs_mag_c;
    logic           dbz_c;
    logic           ov_c;

    assign accept_c  = start && (state != RUN);
    assign dvd_neg_c = isSigned && dividend[W-1];
    assign dvs_neg_c = isSigned && divisor[W-1];
    assign dvd_mag_c = dvd_neg_c ? W'(~dividend + 16'd1) : dividend;
    assign dvs_mag_c = dvs_neg_c ? W'(~divisor + 16'd1) : divisor;
    assign dbz_c     = (divisor == 16'h0000);
    assign ov_c      = isSigned && (dividend == 16'h8000) && (divisor == 16'hFFFF);

    // One restoring step: shift in next dividend bit, trial-subtract the divisor
    logic [W:0]     shifted_c;
    logic           ge_c;
    logic [W-1:0]   r_next_c;
    logic [W-1:0]   q_fin_c;
    logic [W-1:0]   r_fin_c;

    assign shifted_c = {r_acc, q_sh[W-1]};
    assign ge_c      = (shifted_c >= {1'b0, dvs_mag});
    assign r_next_c  = ge_c ? W'(shifted_c - {1'b0, dvs_mag}) : shifted_c[W-1:0];
    assign q_fin_c   = neg_q ? W'(~q_sh + 16'd1) : q_sh;
    assign r_fin_c   = neg_r ? W'(~r_acc + 16'd1) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last      <= 1'b0;
            early_dbz <= 1'b0;
            early_ov  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dvd_raw   <= '0;
            dvs_mag   <= '0;
            q_sh      <= '0;
            r_acc     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
            ovfl      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept_c) begin
                        state     <= RUN;
                        cnt       <= 4'd0;
                        last      <= 1'b0;
                        early_dbz <= dbz_c;
                        early_ov  <= ov_c;
                        neg_q     <= dvd_neg_c ^ dvs_neg_c;
                        neg_r     <= dvd_neg_c;
                        dvd_raw   <= dividend;
                        dvs_mag   <= dvs_mag_c;
                        q_sh      <= dvd_mag_c;
                        r_acc     <= '0;
                        busy      <= !(dbz_c || ov_c);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (early_dbz || early_ov || last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        if (early_dbz) begin
                            quotient  <= 16'hFFFF;
                            remainder <= dvd_raw;
                            divByZero <= 1'b1;
                            ovfl      <= 1'b0;
                        end else if (early_ov) begin
                            quotient  <= 16'h8000;
                            remainder <= 16'h0000;
                            divByZero <= 1'b0;
                            ovfl      <= 1'b1;
                        end else begin
                            quotient  <= q_fin_c;
                            remainder <= r_fin_c;
                            divByZero <= 1'b0;
                            ovfl      <= 1'b0;
                        end
                    end else begin
                        r_acc <= r_next_c;
                        q_sh  <= {q_sh[W-2:0], ge_c};
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            last <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_16.sv
// Directed bench for seq_div_16: hand-computed results, latency, busy span,
// flag behaviour, start-while-running and mid-run reset.
module tb_seq_div_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        isSigned;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        divByZero;
    logic        ovfl;

    int n_checks = 0;
    int n_fail   = 0;

    // Last completed result, as expected by the bench
    logic [15:0] prev_q   = 16'h0000;
    logic [15:0] prev_r   = 16'h0000;
    logic        prev_dbz = 1'b0;
    logic        prev_ov  = 1'b0;

    seq_div_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .isSigned  (isSigned),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero),
        .ovfl      (ovfl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start at edge 0, follow the operation to done and check everything on the way.
    task automatic run_div(input string tag, input logic sgn, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] eq, input logic [15:0] er,
                           input logic edbz, input logic eov, input int restart_edge);
        int done_edge = 0;
        int busy_cnt  = 0;
        int exp_edge  = (edbz || eov) ? 1 : 17;
        int exp_busy  = (edbz || eov) ? 0 : 16;
        @(negedge clk);
        start    = 1'b1;
        isSigned = sgn;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        isSigned = ~sgn;
        dividend = 16'h5A5A;
        divisor  = 16'h0000;
        for (int k = 1; k <= 40; k++) begin
            if (k == restart_edge) begin
                start    = 1'b1;
                isSigned = 1'b1;
                dividend = 16'h1234;
                divisor  = 16'h0003;
            end
            @(posedge clk);
            #1;
            if (k == restart_edge) start = 1'b0;
            if (busy) busy_cnt++;
            if (k == 3 && !(edbz || eov)) begin
                check({tag, "_hold_q"},   32'(quotient),  32'(prev_q));
                check({tag, "_hold_dbz"}, 32'(divByZero), 32'(prev_dbz));
            end
            if (done) begin
                done_edge = k;
                break;
            end
        end
        check({tag, "_done_edge"}, 32'(done_edge), 32'(exp_edge));
        check({tag, "_busy_cyc"},  32'(busy_cnt),  32'(exp_busy));
        check({tag, "_q"},   32'(quotient),  32'(eq));
        check({tag, "_r"},   32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(divByZero), 32'(edbz));
        check({tag, "_ov"},  32'(ovfl),      32'(eov));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_keep_q"}, 32'(quotient), 32'(eq));
        prev_q   = eq;
        prev_r   = er;
        prev_dbz = edbz;
        prev_ov  = eov;
    endtask

    initial begin
        int done_seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        isSigned = 1'b0;
        dividend = 16'h0000;
        divisor  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q",    32'(quotient), 32'd0);
        check("rst_r",    32'(remainder), 32'd0);
        check("rst_dbz",  32'(divByZero), 32'd0);
        check("rst_ov",   32'(ovfl), 32'd0);
        rst_n = 1'b1;

        // start on the first edge after reset release
        run_div("u100_7",   1'b0, 16'd100,  16'd7,     16'h000E, 16'h0002, 1'b0, 1'b0, 0);
        run_div("s-7_2",    1'b1, 16'hFFF9, 16'h0002,  16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 0);
        run_div("u5_0",     1'b0, 16'h0005, 16'h0000,  16'hFFFF, 16'h0005, 1'b1, 1'b0, 0);
        run_div("s_ovf",    1'b1, 16'h8000, 16'hFFFF,  16'h8000, 16'h0000, 1'b0, 1'b1, 0);
        run_div("u_8000",   1'b0, 16'h8000, 16'hFFFF,  16'h0000, 16'h8000, 1'b0, 1'b0, 0);
        run_div("restart",  1'b0, 16'hFFFF, 16'h0010,  16'h0FFF, 16'h000F, 1'b0, 1'b0, 5);
        run_div("u0_5",     1'b0, 16'h0000, 16'h0005,  16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        run_div("u3_10",    1'b0, 16'd3,    16'd10,    16'h0000, 16'h0003, 1'b0, 1'b0, 0);
        run_div("s-100_7",  1'b1, 16'hFF9C, 16'h0007,  16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 0);
        run_div("s100_-7",  1'b1, 16'h0064, 16'hFFF9,  16'hFFF2, 16'h0002, 1'b0, 1'b0, 0);
        run_div("s-5_0",    1'b1, 16'hFFFB, 16'h0000,  16'hFFFF, 16'hFFFB, 1'b1, 1'b0, 0);
        run_div("s8000_2",  1'b1, 16'h8000, 16'h0002,  16'hC000, 16'h0000, 1'b0, 1'b0, 0);

        // Reset asserted at edge 8 of a running division
        @(negedge clk);
        start    = 1'b1;
        isSigned = 1'b0;
        dividend = 16'hFFFF;
        divisor  = 16'h0010;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_q",    32'(quotient), 32'd0);
        check("mid_rst_r",    32'(remainder), 32'd0);
        check("mid_rst_dbz",  32'(divByZero), 32'd0);
        check("mid_rst_ov",   32'(ovfl), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("mid_rst_no_done", 32'(done_seen), 32'd0);
        prev_q   = 16'h0000;
        prev_r   = 16'h0000;
        prev_dbz = 1'b0;
        prev_ov  = 1'b0;
        run_div("post_rst", 1'b0, 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_div_16.md
SEQ_DIV_16 -- requirements
Module: seq_div_16

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request a division; sampled on rising clk.
REQ-004 SHALL have port: isSigned  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL have port: dividend  input  16  numerator; sampled with start.
REQ-006 SHALL have port: divisor  input  16  denominator; sampled with start.
REQ-007 SHALL have port: busy  output  1  iteration in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port: quotient  output  16  registered result.
REQ-010 SHALL have port: remainder  output  16  registered result.
REQ-011 SHALL have port: divByZero  output  1  last operation had divisor 0.
REQ-012 SHALL have port: ovfl  output  1  last operation was signed 0x8000 / 0xFFFF.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on operands, counter or outputs.
REQ-015 On acceptance (edge 0), operands, isSigned and sign info SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-016 Normal path: edge 0 -> RUN, 4-bit iteration counter = 0; busy = 1 from edge 1 through edge 17 (16 cycles).
REQ-017 RUN SHALL perform one restoring-division step per cycle on 16-bit magnitudes: shift partial remainder left with next dividend bit, trial-subtract divisor (17-bit width), keep difference and set quotient bit if non-negative, else restore and clear bit.
REQ-018 After 16th step (edge 17): quotient/remainder registers updated, state -> DONE, done = 1 for exactly one cycle, busy = 0.
REQ-019 DONE SHALL return to IDLE on the next edge unless start is high, in which case a new operation SHALL be accepted.
REQ-020 Signed mode: operands converted to magnitudes; quotient negated iff operand signs differ; remainder takes sign of dividend (truncating division); magnitude of 0x8000 SHALL be treated as 32768 unsigned.
REQ-021 Unsigned mode: no sign conversion; results are pure 16-bit unsigned.
REQ-022 Divisor 0: early-out; done at edge 1, busy never asserted, quotient = 0xFFFF, remainder = dividend, divByZero = 1, ovfl = 0.
REQ-023 Signed 0x8000 / 0xFFFF: early-out at edge 1, quotient = 0x8000, remainder = 0x0000, ovfl = 1, divByZero = 0.
REQ-024 divByZero and ovfl SHALL update only when results update and hold until the next completion.
REQ-025 quotient, remainder, divByZero, ovfl SHALL hold their values between completions, including through IDLE and subsequent RUN.
REQ-026 Dividend 0 or dividend < divisor (unsigned magnitudes) SHALL take the full 16-cycle path with no early-out.

Reset
REQ-027 rst_n low SHALL immediately, without a clock edge, force state IDLE, counter 0, busy 0, done 0, quotient 0x0000, remainder 0x0000, divByZero 0, ovfl 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-029 start high on the first edge after rst_n deasserts SHALL be accepted normally.

Verification
REQ-030 Unsigned 100 / 7, start at edge 0 -> busy edges 1-17, done at edge 17, quotient 0x000E, remainder 0x0002.
REQ-031 Signed 0xFFF9 (-7) / 0x0002 -> quotient 0xFFFD (-3), remainder 0xFFFF (-1), done at edge 17.
REQ-032 Divisor 0, dividend 0x0005 -> done at edge 1, busy 0 throughout, quotient 0xFFFF, remainder 0x0005, divByZero 1.
REQ-033 Signed 0x8000 / 0xFFFF -> done at edge 1, quotient 0x8000, remainder 0x0000, ovfl 1; same operands unsigned -> full path, quotient 0x0000, remainder 0x8000, ovfl 0.
REQ-034 Start 0xFFFF / 0x0010 unsigned, assert start again at edge 5 with other operands -> ignored; done at edge 17 with quotient 0x0FFF, remainder 0x000F.
REQ-035 rst_n low at edge 8 of a division -> all outputs 0 immediately, no done pulse afterward; new start after release completes correctly.
